z80_int_ctrl: RTL and testbench

Z80_INT_CTRL -- requirements
Module: z80_int_ctrl

---
 rtl/z80_bus_pkg.sv | 25 ++
 rtl/prio_enc.sv | 26 ++
 rtl/z80_int_ctrl.sv | 162 ++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 interrupt controller.
// Holds the I/O register offsets, the RETI opcode pair, the index used to
// build the spurious vector, and the controller FSM state encoding.
package z80_bus_pkg;

    localparam logic [1:0] OFS_MASK  = 2'd0;
    localparam logic [1:0] OFS_PEND  = 2'd1;
    localparam logic [1:0] OFS_EOI   = 2'd2;
    localparam logic [1:0] OFS_VBASE = 2'd3;

    localparam logic [7:0] RETI_OP1  = 8'hED;
    localparam logic [7:0] RETI_OP2  = 8'h4D;

    // Index 7 gives vector offset 8'h0E, which no real source can produce
    // because NUM_SRC is at most 7.
    localparam logic [2:0] SPUR_IDX  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK     = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index 0 is highest priority.
// Ports:
//   i_req   - request vector, W bits
//   o_idx   - index of the lowest set request bit (0 when none)
//   o_valid - high when any request bit is set
module prio_enc #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_req,
    output logic [2:0]   o_idx,
    output logic         o_valid
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        o_idx   = 3'd0;
        o_valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 mode-2 style interrupt controller for up to 7 edge-triggered sources.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   irq[NUM_SRC-1:0]      - per-source requests, rising edge captured
//   M1_n/IORQ_n/RD_n/WR_n - Z80 bus strobes, synchronous to clk
//   A, d_in               - Z80 address [7:0] and data toward controller
//   INT_n                 - maskable interrupt request to the CPU
//   d_out, d_oe           - data toward the CPU and its output enable
// Registers at IOADDR_BASE+0 mask, +1 pending, +2 EOI, +3 vector base.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | nothing requested, or waiting for service to finish
// REQ      | INT_n low, waiting for the CPU acknowledge cycle
// ACK      | INTA in progress, vector driven on d_out
// SERVICE  | handler running; ends on EOI write or RETI fetch
module z80_int_ctrl
    import z80_bus_pkg::*;
#(
    parameter int         NUM_SRC      = 4,
    parameter logic [7:0] IOADDR_BASE  = 8'h10,
    parameter logic [7:0] VEC_BASE_RST = 8'h60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               M1_n,
    input  logic               IORQ_n,
    input  logic               RD_n,
    input  logic               WR_n,
    input  logic [7:0]         A,
    input  logic [7:0]         d_in,
    output logic               INT_n,
    output logic [7:0]         d_out,
    output logic               d_oe
);

    state_t             r_state, w_state_nx;
    logic [NUM_SRC-1:0] r_irq_s, r_irq_d, r_pend, r_mask, r_insvc;
    logic [7:0]         r_vbase, r_vector, r_rd_data;
    logic               r_wr_prev, r_fetch_prev, r_ed_seen, r_rd_oe;

    logic               w_inta, w_wr_strb, w_rd_strb, w_fetch;
    logic [7:0]         w_ofs;
    logic [1:0]         w_sel;
    logic               w_hit, w_wr, w_eoi, w_fetch_start, w_reti, w_done;
    logic               w_take, w_valid;
    logic [2:0]         w_idx, w_vec_idx;
    logic [NUM_SRC-1:0] w_edge, w_elig, w_win_1h, w_clr;
    logic [7:0]         w_rd_mux;

    assign w_inta    = ~M1_n & ~IORQ_n;
    assign w_wr_strb = ~IORQ_n & ~WR_n & M1_n;
    assign w_rd_strb = ~IORQ_n & ~RD_n & M1_n;
    assign w_fetch   = ~M1_n & IORQ_n & ~RD_n;

    // Wrapping subtract: any address outside the 4-register window has
    // a non-zero upper part.
    assign w_ofs = A - IOADDR_BASE;
    assign w_sel = w_ofs[1:0];
    assign w_hit = (w_ofs[7:2] == 6'd0);

    // Writes and opcode fetches act once, on the first clk of their strobe.
    assign w_wr          = w_wr_strb & ~r_wr_prev & w_hit;
    assign w_eoi         = w_wr & (w_sel == OFS_EOI);
    assign w_fetch_start = w_fetch & ~r_fetch_prev;
    assign w_reti        = w_fetch_start & r_ed_seen & (d_in == RETI_OP2);
    assign w_done        = w_eoi | w_reti;

    assign w_edge = r_irq_s & ~r_irq_d;
    assign w_elig = r_pend & ~r_mask;

    prio_enc #(.W(NUM_SRC)) u_prio (
        .i_req   (w_elig),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_take    = (r_state == ST_REQ) & w_inta;
    assign w_win_1h  = NUM_SRC'(1) << w_idx;
    assign w_clr     = (w_take && w_valid) ? w_win_1h : '0;
    assign w_vec_idx = w_valid ? w_idx : SPUR_IDX;

    always_comb begin
        case (w_sel)
            OFS_MASK:  w_rd_mux = 8'(r_mask);
            OFS_PEND:  w_rd_mux = 8'(r_pend);
            OFS_VBASE: w_rd_mux = r_vbase;
            default:   w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_s      <= '0;
            r_irq_d      <= '0;
            r_pend       <= '0;
            r_mask       <= '0;
            r_insvc      <= '0;
            r_vbase      <= {VEC_BASE_RST[7:1], 1'b0};
            r_vector     <= 8'h00;
            r_rd_data    <= 8'h00;
            r_wr_prev    <= 1'b0;
            r_fetch_prev <= 1'b0;
            r_ed_seen    <= 1'b0;
            r_rd_oe      <= 1'b0;
        end else begin
            r_irq_s      <= irq;
            r_irq_d      <= r_irq_s;
            // A new edge on the winner in the INTA clk survives the clear.
            r_pend       <= (r_pend & ~w_clr) | w_edge;
            r_wr_prev    <= w_wr_strb;
            r_fetch_prev <= w_fetch;
            if (w_fetch_start)
                r_ed_seen <= (d_in == RETI_OP1);
            if (w_wr && (w_sel == OFS_MASK))
                r_mask <= d_in[NUM_SRC-1:0];
            if (w_wr && (w_sel == OFS_VBASE))
                r_vbase <= {d_in[7:1], 1'b0};
            if (w_take) begin
                r_insvc  <= w_clr;
                r_vector <= r_vbase | {4'b0000, w_vec_idx, 1'b0};
            end else if ((r_state == ST_SERVICE) && w_done) begin
                r_insvc <= '0;
            end
            r_rd_oe   <= w_rd_strb & w_hit;
            r_rd_data <= w_rd_mux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:    if ((|w_elig) && (r_insvc == '0)) w_state_nx = ST_REQ;
            // INTA is checked first so a late mask still yields a vector.
            ST_REQ:     if (w_inta)             w_state_nx = ST_ACK;
                        else if (!(|w_elig))    w_state_nx = ST_IDLE;
            ST_ACK:     if (!w_inta)            w_state_nx = (r_insvc != '0) ? ST_SERVICE : ST_IDLE;
            ST_SERVICE: if (w_done)             w_state_nx = ST_IDLE;
            default:                            w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        INT_n = (r_state != ST_REQ);
        d_oe  = (r_state == ST_ACK) | r_rd_oe;
        if (r_state == ST_ACK)
            d_out = r_vector;
        else if (r_rd_oe)
            d_out = r_rd_data;
        else
            d_out = 8'h00;
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
module tb_z80_int_ctrl;

    localparam int         NSRC = 4;
    localparam logic [7:0] BASE = 8'h10;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq;
    logic            M1_n, IORQ_n, RD_n, WR_n;
    logic [7:0]      A, d_in;
    logic            INT_n;
    logic [7:0]      d_out;
    logic            d_oe;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents as the CPU should see them.
    logic [7:0] m_pend, m_mask, m_vbase;

    z80_int_ctrl #(.NUM_SRC(NSRC), .IOADDR_BASE(BASE), .VEC_BASE_RST(8'h60)) dut (
        .clk(clk), .reset(reset), .irq(irq),
        .M1_n(M1_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .A(A), .d_in(d_in), .INT_n(INT_n), .d_out(d_out), .d_oe(d_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_winner();
        logic [7:0] e;
        e = m_pend & ~m_mask;
        for (int i = 0; i < NSRC; i++)
            if (e[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_vec(input int w);
        if (w < 0) return m_vbase | 8'h0E;
        return m_vbase | 8'(w * 2);
    endfunction

    function automatic void model_reset();
        m_pend  = 8'h00;
        m_mask  = 8'h00;
        m_vbase = 8'h60;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        M1_n = 1'b1; IORQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
        A = 8'h00; d_in = 8'h00;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        A = a; d_in = d; M1_n = 1'b1; IORQ_n = 1'b0; WR_n = 1'b0;
        cyc(); cyc();
        IORQ_n = 1'b1; WR_n = 1'b1;
        cyc();
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] dat, output logic oe);
        A = a; M1_n = 1'b1; IORQ_n = 1'b0; RD_n = 1'b0;
        cyc(); cyc();
        dat = d_out; oe = d_oe;
        IORQ_n = 1'b1; RD_n = 1'b1;
        cyc();
    endtask

    task automatic do_inta(output logic [7:0] vec, output logic oe);
        M1_n = 1'b0; IORQ_n = 1'b0;
        cyc();
        vec = d_out; oe = d_oe;
        cyc();
        M1_n = 1'b1; IORQ_n = 1'b1;
        cyc();
    endtask

    task automatic fetch(input logic [7:0] op);
        M1_n = 1'b0; RD_n = 1'b0; IORQ_n = 1'b1; d_in = op;
        cyc();
        M1_n = 1'b1; RD_n = 1'b1;
        cyc();
    endtask

    // Rising edge on the given sources, held long enough to be captured.
    task automatic pulse_irq(input logic [NSRC-1:0] bits);
        irq = irq | bits;
        cyc(); cyc();
        irq = irq & ~bits;
        cyc();
        m_pend = m_pend | 8'(bits);
    endtask

    task automatic wait_int(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (INT_n === 1'b0) begin ok = 1'b1; return; end
            cyc();
        end
    endtask

    task automatic test_reset();
        logic [7:0] v; logic oe;
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b want 1", INT_n); end
        checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL reset_d_oe: got %b want 0", d_oe); end
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out: got %h want 00", d_out); end
        io_read(BASE + 8'd0, v, oe);
        checks++; if (v !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL reset_mask: got %h oe=%b want 00 oe=1", v, oe); end
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", v); end
        io_read(BASE + 8'd3, v, oe);
        checks++; if (v !== m_vbase) begin errors++; $display("FAIL reset_vbase: got %h want %h", v, m_vbase); end
        checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL read_release_oe: got %b want 0", d_oe); end
    endtask

    task automatic test_basic();
        logic [7:0] v; logic oe; int w;
        irq = 4'b0100;
        cyc();
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL basic_early1: got %b want 1", INT_n); end
        cyc();
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL basic_early2: got %b want 1", INT_n); end
        cyc();
        checks++; if (INT_n !== 1'b0) begin errors++; $display("FAIL basic_int_low: got %b want 0", INT_n); end
        irq = '0;
        m_pend = m_pend | 8'h04;
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL basic_pend: got %h want %h", v, m_pend); end
        w = exp_winner();
        do_inta(v, oe);
        checks++; if (v !== exp_vec(w) || oe !== 1'b1) begin errors++; $display("FAIL basic_vec: got %h oe=%b want %h oe=1", v, oe, exp_vec(w)); end
        m_pend[w] = 1'b0;
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL basic_pend_clr: got %h want %h", v, m_pend); end
        io_write(BASE + 8'd2, 8'h00);
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL basic_after_eoi: got %b want 1", INT_n); end
    endtask

    task automatic test_priority();
        logic [7:0] v; logic oe; int w; bit ok;
        pulse_irq(4'b1010);
        for (int k = 0; k < 2; k++) begin
            wait_int(ok);
            checks++; if (!ok) begin errors++; $display("FAIL prio_wait%0d: INT_n=%b want 0", k, INT_n); end
            w = exp_winner();
            do_inta(v, oe);
            checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL prio_vec%0d: got %h want %h", k, v, exp_vec(w)); end
            if (w >= 0) m_pend[w] = 1'b0;
            io_write(BASE + 8'd2, 8'h00);
        end
    endtask

    task automatic test_mask_req();
        logic [7:0] v; logic oe; int w; bit ok;
        pulse_irq(4'b0001);
        wait_int(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mreq_wait: INT_n=%b want 0", INT_n); end
        A = BASE; d_in = 8'h01; M1_n = 1'b1; IORQ_n = 1'b0; WR_n = 1'b0;
        cyc();
        IORQ_n = 1'b1; WR_n = 1'b1;
        cyc();
        m_mask = 8'h01;
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL mreq_deassert: got %b want 1", INT_n); end
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL mreq_pend: got %h want %h", v, m_pend); end
        io_read(BASE + 8'd0, v, oe);
        checks++; if (v !== m_mask) begin errors++; $display("FAIL mreq_mask_rd: got %h want %h", v, m_mask); end
        io_write(BASE, 8'h00);
        m_mask = 8'h00;
        wait_int(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mreq_unmask: INT_n=%b want 0", INT_n); end
        w = exp_winner();
        do_inta(v, oe);
        checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL mreq_vec: got %h want %h", v, exp_vec(w)); end
        m_pend[w] = 1'b0;
        io_write(BASE + 8'd2, 8'h00);
    endtask

    task automatic test_reti();
        logic [7:0] v; logic oe; int w; bit ok;
        pulse_irq(4'b1000);
        wait_int(ok);
        w = exp_winner();
        do_inta(v, oe);
        checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL reti_vec: got %h want %h", v, exp_vec(w)); end
        m_pend[w] = 1'b0;
        pulse_irq(4'b0010);
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL reti_no_nest: got %b want 1", INT_n); end
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL reti_pend: got %h want %h", v, m_pend); end
        fetch(8'hED); fetch(8'h00); fetch(8'h4D);
        cyc(); cyc();
        checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL reti_broken_seq: got %b want 1", INT_n); end
        fetch(8'hED); fetch(8'h4D);
        wait_int(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reti_clear: INT_n=%b want 0", INT_n); end
        w = exp_winner();
        do_inta(v, oe);
        checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL reti_vec2: got %h want %h", v, exp_vec(w)); end
        m_pend[w] = 1'b0;
        fetch(8'hED); fetch(8'h4D);
        pulse_irq(4'b0100);
        wait_int(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reti_end2: INT_n=%b want 0", INT_n); end
        w = exp_winner();
        do_inta(v, oe);
        m_pend[w] = 1'b0;
        io_write(BASE + 8'd2, 8'h00);
    endtask

    task automatic test_spurious();
        logic [7:0] v; logic oe; int w; bit ok;
        pulse_irq(4'b0001);
        wait_int(ok);
        A = BASE; d_in = 8'h01; M1_n = 1'b1; IORQ_n = 1'b0; WR_n = 1'b0;
        cyc();
        m_mask = 8'h01;
        WR_n = 1'b1; M1_n = 1'b0;
        cyc();
        w = exp_winner();
        checks++; if (d_oe !== 1'b1 || d_out !== exp_vec(w)) begin errors++; $display("FAIL spur_vec: got %h oe=%b want %h oe=1", d_out, d_oe, exp_vec(w)); end
        cyc();
        M1_n = 1'b1; IORQ_n = 1'b1;
        cyc();
        checks++; if (INT_n !== 1'b1 || d_oe !== 1'b0) begin errors++; $display("FAIL spur_idle: INT_n=%b d_oe=%b want 1 0", INT_n, d_oe); end
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL spur_pend: got %h want %h", v, m_pend); end
        io_write(BASE, 8'h00);
        m_mask = 8'h00;
        wait_int(ok);
        checks++; if (!ok) begin errors++; $display("FAIL spur_no_insvc: INT_n=%b want 0", INT_n); end
        w = exp_winner();
        do_inta(v, oe);
        checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL spur_vec2: got %h want %h", v, exp_vec(w)); end
        m_pend[w] = 1'b0;
        io_write(BASE + 8'd2, 8'h00);
        io_write(BASE + 8'd3, 8'h81);
        m_vbase = 8'h81 & 8'hFE;
        io_read(BASE + 8'd3, v, oe);
        checks++; if (v !== m_vbase) begin errors++; $display("FAIL vbase_rd: got %h want %h", v, m_vbase); end
        pulse_irq(4'b0100);
        wait_int(ok);
        w = exp_winner();
        do_inta(v, oe);
        checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL vbase_vec: got %h want %h", v, exp_vec(w)); end
        m_pend[w] = 1'b0;
        io_write(BASE + 8'd2, 8'h00);
        io_write(BASE + 8'd3, 8'h60);
        m_vbase = 8'h60;
    endtask

    task automatic test_set_wins();
        logic [7:0] v; logic oe; int w; bit ok;
        irq = 4'b0010;
        wait_int(ok);
        m_pend = m_pend | 8'h02;
        irq = '0;
        cyc(); cyc();
        irq = 4'b0010;
        cyc();
        M1_n = 1'b0; IORQ_n = 1'b0;
        cyc();
        w = exp_winner();
        checks++; if (d_out !== exp_vec(w)) begin errors++; $display("FAIL setwin_vec: got %h want %h", d_out, exp_vec(w)); end
        cyc();
        M1_n = 1'b1; IORQ_n = 1'b1; irq = '0;
        cyc();
        // The clear and the fresh edge land together: still pending.
        m_pend[w] = 1'b0;
        m_pend = m_pend | 8'h02;
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL setwin_pend: got %h want %h", v, m_pend); end
        io_write(BASE + 8'd2, 8'h00);
        wait_int(ok);
        checks++; if (!ok) begin errors++; $display("FAIL setwin_rereq: INT_n=%b want 0", INT_n); end
        w = exp_winner();
        do_inta(v, oe);
        m_pend[w] = 1'b0;
        io_write(BASE + 8'd2, 8'h00);
    endtask

    task automatic test_reset_in_ack();
        logic [7:0] v; logic oe; bit ok;
        io_write(BASE, 8'h0A); m_mask = 8'h0A;
        io_write(BASE + 8'd3, 8'h40); m_vbase = 8'h40;
        pulse_irq(4'b1000);
        pulse_irq(4'b0100);
        wait_int(ok);
        M1_n = 1'b0; IORQ_n = 1'b0;
        cyc();
        checks++; if (d_oe !== 1'b1) begin errors++; $display("FAIL rack_oe: got %b want 1", d_oe); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (d_oe !== 1'b0 || INT_n !== 1'b1 || d_out !== 8'h00) begin errors++; $display("FAIL rack_async: d_oe=%b INT_n=%b d_out=%h want 0 1 00", d_oe, INT_n, d_out); end
        cyc();
        reset = 1'b0;
        model_reset();
        cyc();
        checks++; if (d_oe !== 1'b0 || INT_n !== 1'b1) begin errors++; $display("FAIL rack_release: d_oe=%b INT_n=%b want 0 1", d_oe, INT_n); end
        M1_n = 1'b1; IORQ_n = 1'b1;
        cyc();
        io_read(BASE + 8'd0, v, oe);
        checks++; if (v !== m_mask) begin errors++; $display("FAIL rack_mask: got %h want %h", v, m_mask); end
        io_read(BASE + 8'd1, v, oe);
        checks++; if (v !== m_pend) begin errors++; $display("FAIL rack_pend: got %h want %h", v, m_pend); end
        io_read(BASE + 8'd3, v, oe);
        checks++; if (v !== m_vbase) begin errors++; $display("FAIL rack_vbase: got %h want %h", v, m_vbase); end
    endtask

    task automatic test_random();
        logic [7:0] v; logic oe; int w; bit ok;
        logic [NSRC-1:0] p1, p2, mk;
        logic [7:0] vb;
        for (int it = 0; it < 25; it++) begin
            vb = 8'($urandom_range(0, 255));
            io_write(BASE + 8'd3, vb); m_vbase = vb & 8'hFE;
            mk = NSRC'($urandom_range(0, (1 << NSRC) - 1));
            io_write(BASE, 8'(mk)); m_mask = 8'(mk);
            p1 = NSRC'($urandom_range(1, (1 << NSRC) - 1));
            pulse_irq(p1);
            w = exp_winner();
            if (w < 0) begin
                cyc();
                checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL rnd_masked%0d: INT_n=%b want 1", it, INT_n); end
                io_read(BASE + 8'd1, v, oe);
                checks++; if (v !== m_pend) begin errors++; $display("FAIL rnd_pend%0d: got %h want %h", it, v, m_pend); end
            end else begin
                wait_int(ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_wait%0d: INT_n=%b want 0", it, INT_n); end
                do_inta(v, oe);
                checks++; if (v !== exp_vec(w)) begin errors++; $display("FAIL rnd_vec%0d: got %h want %h", it, v, exp_vec(w)); end
                m_pend[w] = 1'b0;
                p2 = NSRC'($urandom_range(0, (1 << NSRC) - 1));
                if (p2 != '0) pulse_irq(p2);
                checks++; if (INT_n !== 1'b1) begin errors++; $display("FAIL rnd_nonest%0d: INT_n=%b want 1", it, INT_n); end
                if ($urandom_range(0, 1) == 1) begin
                    fetch(8'hED); fetch(8'h4D);
                end else begin
                    io_write(BASE + 8'd2, 8'h00);
                end
            end
            io_write(BASE, 8'h00); m_mask = 8'h00;
            for (int d = 0; d < NSRC && m_pend != 8'h00; d++) begin
                wait_int(ok);
                w = exp_winner();
                do_inta(v, oe);
                checks++; if (!ok || v !== exp_vec(w)) begin errors++; $display("FAIL rnd_drain%0d: got %h ok=%0d want %h", it, v, ok, exp_vec(w)); end
                m_pend[w] = 1'b0;
                io_write(BASE + 8'd2, 8'h00);
            end
            io_read(BASE + 8'd1, v, oe);
            checks++; if (v !== m_pend || INT_n !== 1'b1) begin errors++; $display("FAIL rnd_empty%0d: pend=%h INT_n=%b want %h 1", it, v, INT_n, m_pend); end
        end
    endtask

    initial begin
        reset = 1'b1;
        irq = '0;
        idle_bus();
        model_reset();
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        test_reset();
        test_basic();
        test_priority();
        test_mask_req();
        test_reti();
        test_spurious();
        test_set_wins();
        test_reset_in_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
